vector_adder_sequencer: RTL and testbench

- Sequences the 64-bit byte-sliced vector adder across one vector operation of vl elements, one 64-bit beat per accepted operand pair.
- Slices v0 carry/borrow bits per beat, drives the adder's control inputs, and streams sum results with tail zeroing.
- For carry-out operations (vmadc/vmsbc), packs per-beat carry bits into a 64-bit mask result instead of streaming.
- Sits between the vector register-file read port and the writeback stage in the integer vector lane.

---
 rtl/vector_adder_sequencer.sv | 150 +++++++++++++++
 tb/tb_vector_adder_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vector_adder_sequencer.sv
// vector_adder_sequencer: drives a byte-sliced 64-bit vector adder across one vl-element operation,
// streaming tail-zeroed sums or packing per-element carry/borrow-out bits into a mask.
module vector_adder_sequencer #(
  parameter int MAX_VL = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [6:0]        vl_i,
  input  logic [1:0]        vsew_i,
  input  logic              add_sub_i,
  input  logic              compute_carry_i,
  input  logic              with_carry_borrow_i,
  input  logic              reversed_i,
  input  logic [MAX_VL-1:0] v0_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              opnd_valid_i,
  output logic              opnd_ready_o,
  input  logic [63:0]       vs2_data_i,
  input  logic [63:0]       vs1_data_i,
  output logic [63:0]       adder_vs2_o,
  output logic [63:0]       adder_vs1_o,
  output logic [7:0]        adder_vmask_o,
  output logic [1:0]        adder_vsew_o,
  output logic              adder_add_sub_o,
  output logic              adder_compute_carry_o,
  output logic              adder_with_carry_borrow_o,
  output logic              adder_reversed_o,
  input  logic [63:0]       adder_vd_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [63:0]       res_data_o,
  output logic              res_last_o,
  output logic [MAX_VL-1:0] mask_o
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state_q, state_d;
  logic [6:0] vl_q, vl_d, b_q, b_d;
  logic [1:0] vsew_q, vsew_d;
  logic add_sub_q, add_sub_d, cc_q, cc_d, wcb_q, wcb_d, rev_q, rev_d;
  logic [MAX_VL-1:0] v0_q, v0_d, mask_q, mask_d;
  logic res_valid_q, res_valid_d, res_last_q, res_last_d;
  logic [63:0] res_data_q, res_data_d, keep;
  logic [1:0] sh;
  logic [3:0] epb;
  logic [7:0] beats, elem_ok, byte_ok, v0_sl, cbits;
  logic [9:0] base;
  logic accept, last_beat;
  assign sh = 2'd3 - vsew_q;
  assign epb = 4'd8 >> vsew_q;
  assign beats = (8'(vl_q) + 8'(epb) - 8'd1) >> sh;
  assign base = 10'(b_q) << sh;
  // elem_ok marks in-range element slots of this beat; byte_ok maps each byte to its element
  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign elem_ok[i] = (4'(i) < epb) && (base + 10'(i) < 10'(vl_q));
    assign byte_ok[i] = (base + (10'(i) >> vsew_q)) < 10'(vl_q);
    assign keep[8*i +: 8] = {8{byte_ok[i]}};
  end
  assign v0_sl = 8'(v0_q >> base);
  assign cbits = adder_vd_i[7:0] & elem_ok;
  assign opnd_ready_o = (state_q == RUN) && (8'(b_q) < beats) && (cc_q || !res_valid_q || res_ready_i);
  assign accept = opnd_valid_i && opnd_ready_o;
  assign last_beat = 8'(b_q) == beats - 8'd1;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == FINISH;
  assign adder_vs2_o = vs2_data_i;
  assign adder_vs1_o = vs1_data_i;
  assign adder_vmask_o = {8{wcb_q}} & elem_ok & v0_sl;
  assign adder_vsew_o = vsew_q;
  assign adder_add_sub_o = add_sub_q;
  assign adder_compute_carry_o = cc_q;
  assign adder_with_carry_borrow_o = wcb_q;
  assign adder_reversed_o = rev_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o = res_data_q;
  assign res_last_o = res_last_q;
  assign mask_o = mask_q;
  always_comb begin
    state_d = state_q;
    b_d = b_q;
    vl_d = vl_q;
    vsew_d = vsew_q;
    add_sub_d = add_sub_q;
    cc_d = cc_q;
    wcb_d = wcb_q;
    rev_d = rev_q;
    v0_d = v0_q;
    mask_d = mask_q;
    res_valid_d = res_valid_q && !res_ready_i;
    res_last_d = res_last_q && !res_ready_i;
    res_data_d = res_data_q;
    if (state_q == IDLE && start_i) begin
      vl_d = vl_i;
      vsew_d = vsew_i;
      add_sub_d = add_sub_i;
      cc_d = compute_carry_i;
      wcb_d = with_carry_borrow_i;
      rev_d = reversed_i;
      v0_d = v0_i;
      mask_d = '0;
      b_d = '0;
      state_d = vl_i == 7'd0 ? FINISH : RUN;
    end
    if (state_q == FINISH) state_d = IDLE;
    if (accept) begin
      b_d = b_q + 7'd1;
      if (cc_q) begin
        mask_d = mask_q | (MAX_VL'(cbits) << base);
        state_d = last_beat ? FINISH : state_d;
      end else begin
        res_valid_d = 1'b1;
        res_last_d = last_beat;
        res_data_d = adder_vd_i & keep;
      end
    end
    if (state_q == RUN && !cc_q && res_valid_q && res_ready_i && res_last_q) state_d = FINISH;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      b_q <= '0;
      vl_q <= '0;
      vsew_q <= '0;
      add_sub_q <= 1'b0;
      cc_q <= 1'b0;
      wcb_q <= 1'b0;
      rev_q <= 1'b0;
      v0_q <= '0;
      mask_q <= '0;
      res_valid_q <= 1'b0;
      res_last_q <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q <= state_d;
      b_q <= b_d;
      vl_q <= vl_d;
      vsew_q <= vsew_d;
      add_sub_q <= add_sub_d;
      cc_q <= cc_d;
      wcb_q <= wcb_d;
      rev_q <= rev_d;
      v0_q <= v0_d;
      mask_q <= mask_d;
      res_valid_q <= res_valid_d;
      res_last_q <= res_last_d;
      res_data_q <= res_data_d;
    end
  end
endmodule

// File: tb/tb_vector_adder_sequencer.sv
// tb_vector_adder_sequencer: directed operations; driver pushes expected result beats, monitor pops and compares.
module tb_vector_adder_sequencer;
  logic clk = 1'b0, rst_i = 1'b1;
  always #5 clk = ~clk;
  logic start_i = 0, add_sub_i = 0, compute_carry_i = 0, with_carry_borrow_i = 0, reversed_i = 0;
  logic [6:0] vl_i = 0;
  logic [1:0] vsew_i = 0;
  logic [63:0] v0_i = 0, vs2_data_i = 0, vs1_data_i = 0, adder_vd_i = 0;
  logic opnd_valid_i = 0, res_ready_i = 1;
  logic busy_o, done_o, opnd_ready_o, res_valid_o, res_last_o;
  logic [63:0] adder_vs2_o, adder_vs1_o, res_data_o, mask_o;
  logic [7:0] adder_vmask_o;
  logic [1:0] adder_vsew_o;
  logic adder_add_sub_o, adder_compute_carry_o, adder_with_carry_borrow_o, adder_reversed_o;
  vector_adder_sequencer #(.MAX_VL(64)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .vl_i(vl_i), .vsew_i(vsew_i),
    .add_sub_i(add_sub_i), .compute_carry_i(compute_carry_i),
    .with_carry_borrow_i(with_carry_borrow_i), .reversed_i(reversed_i), .v0_i(v0_i),
    .busy_o(busy_o), .done_o(done_o), .opnd_valid_i(opnd_valid_i), .opnd_ready_o(opnd_ready_o),
    .vs2_data_i(vs2_data_i), .vs1_data_i(vs1_data_i), .adder_vs2_o(adder_vs2_o),
    .adder_vs1_o(adder_vs1_o), .adder_vmask_o(adder_vmask_o), .adder_vsew_o(adder_vsew_o),
    .adder_add_sub_o(adder_add_sub_o), .adder_compute_carry_o(adder_compute_carry_o),
    .adder_with_carry_borrow_o(adder_with_carry_borrow_o), .adder_reversed_o(adder_reversed_o),
    .adder_vd_i(adder_vd_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_last_o(res_last_o), .mask_o(mask_o)
  );
  int checks = 0, errors = 0;
  typedef struct packed {logic [63:0] d; logic l;} res_t;
  res_t sb[$];
  logic [63:0] vs2_t[8], vs1_t[8], vd_t[8], exp_t[8];
  logic [7:0] vm_t[8];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    res_t e;
    if (res_valid_o && res_ready_i) begin
      if (sb.size() == 0) chk("res_unexpected", {63'd0, res_valid_o}, 64'd0);
      else begin
        e = sb.pop_front();
        chk("res_data", res_data_o, e.d);
        chk("res_last", {63'd0, res_last_o}, {63'd0, e.l});
      end
    end
  end
  task automatic chk_all_zero(input string nm);
    chk(nm, {56'd0, busy_o, done_o, opnd_ready_o, res_valid_o, res_last_o, adder_add_sub_o,
             adder_compute_carry_o, adder_with_carry_borrow_o}, 64'd0);
    chk({nm, "_ctl"}, {61'd0, adder_reversed_o, adder_vsew_o}, 64'd0);
    chk({nm, "_data"}, res_data_o, 64'd0);
    chk({nm, "_mask"}, mask_o, 64'd0);
  endtask
  task automatic run_op(input logic [1:0] sew, input logic [6:0] vl, input logic as, input logic cc,
                        input logic wcb, input logic rev, input logic [63:0] v0, input logic [63:0] exp_mask,
                        input int nb, input int stall, input int abort);
    int n;
    @(posedge clk); #1;
    start_i = 1; vsew_i = sew; vl_i = vl; add_sub_i = as; compute_carry_i = cc;
    with_carry_borrow_i = wcb; reversed_i = rev; v0_i = v0;
    @(posedge clk); #1;
    start_i = 0; vsew_i = ~sew; vl_i = 7'd0; add_sub_i = ~as; compute_carry_i = ~cc;
    with_carry_borrow_i = ~wcb; reversed_i = ~rev; v0_i = ~v0;
    for (int i = 0; i < nb; i++) begin
      if (!cc) sb.push_back('{d: exp_t[i], l: (i == nb - 1)});
      vs2_data_i = vs2_t[i]; vs1_data_i = vs1_t[i]; adder_vd_i = vd_t[i]; opnd_valid_i = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!opnd_ready_o && n < 20);
      if (i == abort) begin
        rst_i = 1; #1;
        chk_all_zero("abort_reset");
        rst_i = 0; opnd_valid_i = 0; sb.delete();
        repeat (4) begin @(negedge clk); chk("abort_idle", {62'd0, done_o, busy_o}, 64'd0); end
        return;
      end
      chk("opnd_ready", {63'd0, opnd_ready_o}, 64'd1);
      chk("busy", {63'd0, busy_o}, 64'd1);
      chk("adder_vmask", {56'd0, adder_vmask_o}, {56'd0, vm_t[i]});
      chk("adder_vs2", adder_vs2_o, vs2_t[i]);
      chk("adder_vs1", adder_vs1_o, vs1_t[i]);
      if (i == 0) chk("adder_ctrl", {58'd0, adder_vsew_o, adder_add_sub_o, adder_compute_carry_o,
                      adder_with_carry_borrow_o, adder_reversed_o}, {58'd0, sew, as, cc, wcb, rev});
      @(posedge clk); #1;
      if (i == 0 && stall > 0) begin
        res_ready_i = 0;
        repeat (stall) begin @(negedge clk); chk("stall_ready", {63'd0, opnd_ready_o}, 64'd0); end
        @(posedge clk); #1;
        res_ready_i = 1;
      end
    end
    opnd_valid_i = 0;
    n = 0;
    do begin
      @(negedge clk); n++;
      chk("no_opnd_ready", {63'd0, opnd_ready_o}, 64'd0);
    end while (!done_o && n < 20);
    chk("done", {63'd0, done_o}, 64'd1);
    chk("done_latency", 64'(n), (cc || nb == 0) ? 64'd1 : 64'd2);
    chk("mask", mask_o, exp_mask);
    @(negedge clk);
    chk("done_pulse", {62'd0, done_o, busy_o}, 64'd0);
    chk("mask_held", mask_o, exp_mask);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_i = 0;
    // vadd SEW8 vl=8
    vs2_t[0] = 64'h0102030405060708; vs1_t[0] = 64'h0101010101010101;
    vd_t[0] = 64'h0203040506070809; exp_t[0] = 64'h0203040506070809; vm_t[0] = 8'h00;
    run_op(2'd0, 7'd8, 0, 0, 0, 0, 64'h0, 64'h0, 1, 0, -1);
    // vadc SEW32 vl=3, element 3 tail-zeroed even though v0[3]=1
    for (int i = 0; i < 2; i++) begin
      vs2_t[i] = 64'h0000000100000001; vs1_t[i] = 64'h0000000100000001;
      vd_t[i] = 64'h0000000200000003; vm_t[i] = 8'h01;
    end
    exp_t[0] = 64'h0000000200000003; exp_t[1] = 64'h0000000000000003;
    run_op(2'd2, 7'd3, 0, 0, 1, 0, 64'hD, 64'h0, 2, 0, -1);
    // vmadc SEW16 vl=5
    for (int i = 0; i < 2; i++) begin
      vs2_t[i] = 64'hFFFFFFFFFFFFFFFF; vs1_t[i] = 64'h0001000100010001;
      vd_t[i] = 64'h00000000000000FF; vm_t[i] = 8'h00;
    end
    run_op(2'd1, 7'd5, 0, 1, 0, 0, 64'h0, 64'h1F, 2, 0, -1);
    // vsub SEW64 vl=4 with 3-cycle writeback stall after beat 0
    for (int i = 0; i < 4; i++) begin
      vs2_t[i] = 64'hA5A5A5A5A5A5A5A5 + 64'(i); vs1_t[i] = 64'h0F0F0F0F0F0F0F0F;
      vd_t[i] = 64'h1111111111111111 * 64'(i + 1); exp_t[i] = vd_t[i]; vm_t[i] = 8'h00;
    end
    run_op(2'd3, 7'd4, 1, 0, 0, 0, 64'h0, 64'h0, 4, 3, -1);
    // vl=0
    run_op(2'd0, 7'd0, 0, 0, 0, 0, 64'hFFFF, 64'h0, 0, 0, -1);
    // vadc SEW8 vl=5 reversed, byte tail zeroing and v0 gap at element 4
    vs2_t[0] = 64'h0; vs1_t[0] = 64'h0;
    vd_t[0] = 64'h1122334455667788; exp_t[0] = 64'h0000004455667788; vm_t[0] = 8'h0F;
    run_op(2'd0, 7'd5, 1, 0, 1, 1, 64'hEF, 64'h0, 1, 0, -1);
    // vadc SEW8 vl=12, second beat slices v0[15:8]
    vs2_t[0] = 64'h1; vs1_t[0] = 64'h2; vd_t[0] = 64'h0123456789ABCDEF; exp_t[0] = 64'h0123456789ABCDEF;
    vm_t[0] = 8'h5F;
    vs2_t[1] = 64'h3; vs1_t[1] = 64'h4; vd_t[1] = 64'hFFFFFFFFFFFFFFFF; exp_t[1] = 64'h00000000FFFFFFFF;
    vm_t[1] = 8'h0A;
    run_op(2'd0, 7'd12, 0, 0, 1, 0, 64'hFA5F, 64'h0, 2, 0, -1);
    // reset during beat 2 of 4, then a normal operation
    for (int i = 0; i < 4; i++) begin
      vs2_t[i] = 64'(i); vs1_t[i] = 64'(i);
      vd_t[i] = 64'hCAFE000000000000 + 64'(i); exp_t[i] = vd_t[i]; vm_t[i] = 8'h00;
    end
    run_op(2'd3, 7'd4, 0, 0, 0, 0, 64'h0, 64'h0, 4, 0, 2);
    vs2_t[0] = 64'h0102030405060708; vs1_t[0] = 64'h0101010101010101;
    vd_t[0] = 64'h0203040506070809; exp_t[0] = 64'h0203040506070809; vm_t[0] = 8'h00;
    run_op(2'd0, 7'd8, 0, 0, 0, 0, 64'h0, 64'h0, 1, 0, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
